// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter: parameter defaults, FSM
// encoding, counter width and the grant-index width helper.
package fifo_wr_arbiter_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_NUM_REQ    = 4;
  localparam int PUSH_CNT_W         = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PUSH = 1'b1
  } state_t;

  // Grant index width; a single-bit index is kept even for degenerate sizes.
  function automatic int grant_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage : fifo_wr_arbiter_pkg

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of the eligible mask,
// searching upward from (last_grant + 1) mod NUM_REQ with wrap-around.
module fifo_wr_arbiter_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int GRANT_W = grant_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [GRANT_W-1:0] last_grant,
  output logic               valid,
  output logic [GRANT_W-1:0] grant
);

  logic [GRANT_W-1:0] cand;

  // Walk the offsets from farthest to nearest so the nearest eligible
  // requester is the last one written and therefore wins.
  always_comb begin
    // NOTE: every output gets a default first, so no path can leave it
    // unassigned and infer a latch.
    valid = 1'b0;
    grant = '0;
    cand  = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = GRANT_W'((int'(last_grant) + off) % NUM_REQ);
      if (eligible[cand]) begin
        valid = 1'b1;
        grant = cand;
      end
    end
  end

endmodule : fifo_wr_arbiter_rr_pick

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ push requesters into one FIFO write
// port; one registered push per cycle, requester acked in the push cycle.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int NUM_REQ    = DEFAULT_NUM_REQ,
  localparam int GRANT_W    = grant_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          fifo_full,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          fifo_push,
  output logic [DATA_WIDTH-1:0]         fifo_write_data,
  output logic [GRANT_W-1:0]            grant_id,
  output logic [PUSH_CNT_W-1:0]         push_count
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("fifo_wr_arbiter: NUM_REQ must be in 2..8");
  end

  state_t                 state;
  logic [GRANT_W-1:0]     last_grant;
  logic [NUM_REQ-1:0]     eligible;
  logic                   pick_valid;
  logic [GRANT_W-1:0]     pick_idx;
  logic                   grant_now;
  logic [DATA_WIDTH-1:0]  pick_data;
  logic [NUM_REQ-1:0]     pick_onehot;

  // A requester acked this cycle is still showing req (its handshake is
  // completing now), so it must sit out this edge.
  assign eligible  = req & ~ack;
  assign grant_now = pick_valid & ~fifo_full;

  fifo_wr_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GRANT_W (GRANT_W)
  ) u_rr_pick (
    .eligible   (eligible),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .grant      (pick_idx)
  );

  // Word mux and one-hot decode of the picked index.
  always_comb begin
    pick_data   = '0;
    pick_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == GRANT_W'(i)) begin
        pick_data      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        pick_onehot[i] = 1'b1;
      end
    end
  end

  assign fifo_push = (state == ST_PUSH);

  // NOTE: last_grant resets to NUM_REQ-1 rather than 0 so the first search
  // starts at requester 0; every other register clears to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      ack             <= '0;
      fifo_write_data <= '0;
      grant_id        <= '0;
      push_count      <= '0;
      last_grant      <= GRANT_W'(NUM_REQ - 1);
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples the pre-edge values of its neighbours.
      ack <= grant_now ? pick_onehot : '0;

      case (state)
        ST_IDLE: state <= grant_now ? ST_PUSH : ST_IDLE;
        ST_PUSH: state <= grant_now ? ST_PUSH : ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (grant_now) begin
        fifo_write_data <= pick_data;
        grant_id        <= pick_idx;
        last_grant      <= pick_idx;
        push_count      <= push_count + PUSH_CNT_W'(1);
      end
    end
  end

endmodule : fifo_wr_arbiter

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter: a vector table for the
// steady-state arbitration plus hand sequences for reset and wrap corners.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int GW = 2;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic             fifo_full;
  logic [NR-1:0]    ack;
  logic             fifo_push;
  logic [DW-1:0]    fifo_write_data;
  logic [GW-1:0]    grant_id;
  logic [15:0]      push_count;

  int errors = 0;
  int checks = 0;

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .req_data        (req_data),
    .fifo_full       (fifo_full),
    .ack             (ack),
    .fifo_push       (fifo_push),
    .fifo_write_data (fifo_write_data),
    .grant_id        (grant_id),
    .push_count      (push_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic        full;
    logic        push;
    logic [3:0]  ack;
    logic [7:0]  data;
    logic [1:0]  gid;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req       = '0;
    fifo_full = 1'b0;
    req_data  = 32'h1312_1110;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic check_outputs(input string tag, input logic push,
                               input logic [3:0] a, input logic [7:0] d,
                               input logic [1:0] g, input logic [15:0] c);
    check({tag, ".push"}, 32'(fifo_push), 32'(push));
    check({tag, ".ack"},  32'(ack),       32'(a));
    check({tag, ".data"}, 32'(fifo_write_data), 32'(d));
    check({tag, ".gid"},  32'(grant_id),  32'(g));
    check({tag, ".cnt"},  32'(push_count), 32'(c));
  endtask

  initial begin
    int pushes;

    // Starts right after reset release: last_grant = 3.
    for (int i = 0; i < 5; i++)
      vecs[i] = '{4'b0101, 1'b1, 1'b0, 4'b0000, 8'h00, 2'd0, 16'd0};
    vecs[5]  = '{4'b0101, 1'b0, 1'b1, 4'b0001, 8'h10, 2'd0, 16'd1};
    vecs[6]  = '{4'b0101, 1'b0, 1'b1, 4'b0100, 8'h12, 2'd2, 16'd2};
    vecs[7]  = '{4'b0101, 1'b0, 1'b1, 4'b0001, 8'h10, 2'd0, 16'd3};
    vecs[8]  = '{4'b1111, 1'b0, 1'b1, 4'b0010, 8'h11, 2'd1, 16'd4};
    vecs[9]  = '{4'b1111, 1'b0, 1'b1, 4'b0100, 8'h12, 2'd2, 16'd5};
    vecs[10] = '{4'b1111, 1'b0, 1'b1, 4'b1000, 8'h13, 2'd3, 16'd6};
    vecs[11] = '{4'b1111, 1'b0, 1'b1, 4'b0001, 8'h10, 2'd0, 16'd7};
    vecs[12] = '{4'b1111, 1'b0, 1'b1, 4'b0010, 8'h11, 2'd1, 16'd8};
    vecs[13] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 8'h11, 2'd1, 16'd8};
    vecs[14] = '{4'b1000, 1'b0, 1'b1, 4'b1000, 8'h13, 2'd3, 16'd9};
    vecs[15] = '{4'b1000, 1'b0, 1'b0, 4'b0000, 8'h13, 2'd3, 16'd9};
    vecs[16] = '{4'b1010, 1'b1, 1'b0, 4'b0000, 8'h13, 2'd3, 16'd9};
    vecs[17] = '{4'b1010, 1'b0, 1'b1, 4'b0010, 8'h11, 2'd1, 16'd10};

    // Held in reset with every requester active: nothing may move.
    rst       = 1'b0;
    req       = 4'b1111;
    fifo_full = 1'b0;
    req_data  = 32'h1312_1110;
    tick();
    tick();
    tick();
    check_outputs("rst_hold", 1'b0, 4'b0000, 8'h00, 2'd0, 16'd0);
    rst = 1'b1;
    tick();
    check_outputs("rst_first", 1'b1, 4'b0001, 8'h10, 2'd0, 16'd1);

    // Vector table.
    do_reset();
    for (int v = 0; v < 18; v++) begin
      req       = vecs[v].req;
      fifo_full = vecs[v].full;
      tick();
      check_outputs($sformatf("vec%0d", v), vecs[v].push, vecs[v].ack,
                    vecs[v].data, vecs[v].gid, vecs[v].cnt);
    end

    // Lone requester held for six cycles: pushes on alternate cycles.
    do_reset();
    req_data[23:16] = 8'hA5;
    req    = 4'b0100;
    pushes = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (fifo_push) pushes++;
      check($sformatf("solo%0d.push", i), 32'(fifo_push), 32'((i % 2) == 0));
      check($sformatf("solo%0d.ack", i), 32'(ack),
            (i % 2) == 0 ? 32'h4 : 32'h0);
      check($sformatf("solo%0d.data", i), 32'(fifo_write_data), 32'hA5);
    end
    req = '0;
    check("solo.total", 32'(pushes), 32'd3);

    // Requester withdraws while blocked: no stale push afterwards.
    do_reset();
    fifo_full = 1'b1;
    req       = 4'b0010;
    tick();
    tick();
    check("drop.blocked", 32'(fifo_push), 32'd0);
    req       = '0;
    fifo_full = 1'b0;
    tick();
    tick();
    check_outputs("drop.after", 1'b0, 4'b0000, 8'h00, 2'd0, 16'd0);

    // Asynchronous reset in the middle of a push cycle.
    do_reset();
    req = 4'b1111;
    tick();
    tick();
    tick();
    check("mid.push_before", 32'(fifo_push), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    check_outputs("mid.async", 1'b0, 4'b0000, 8'h00, 2'd0, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    check_outputs("mid.restart", 1'b1, 4'b0001, 8'h10, 2'd0, 16'd1);

    // Counter wrap: 65537 back-to-back pushes.
    do_reset();
    req = 4'b1111;
    repeat (65535) tick();
    check("wrap.ffff", 32'(push_count), 32'hFFFF);
    tick();
    check("wrap.0000", 32'(push_count), 32'h0000);
    tick();
    check("wrap.0001", 32'(push_count), 32'h0001);
    check("wrap.push", 32'(fifo_push), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fifo_wr_arbiter
